comparator_bist: RTL and testbench
==================================

Name: comparator_bist

Overview:
Self-test initiator for the 4-bit magnitude comparator (a/b in; a_greater/a_equal/a_less out). On start it drives every (a,b) operand pair into the comparator under test and waits a programmable settle time. It then samples the comparator's three outputs and checks them against an internal golden result, counting mismatches. It sits beside the comparator as the driving-and-checking end of that interface and reports done/pass plus the first failing vector.

Parameters:
WIDTH, 4, operand width of the comparator under test.
SETTLE, 1, cycles the comparator outputs are given to settle before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that begins a full sweep; honoured only in IDLE or DONE.
dut_a  output  WIDTH  operand a driven to the comparator under test.
dut_b  output  WIDTH  operand b driven to the comparator under test.
dut_greater  input  1  comparator a_greater result.
dut_equal  input  1  comparator a_equal result.
dut_less  input  1  comparator a_less result.
busy  output  1  high while a sweep is in progress.
done  output  1  high from sweep completion until the next accepted start or reset.
pass  output  1  valid when done=1; 1 means err_count==0.
err_count  output  2*WIDTH+1  number of failing vectors in the current or last sweep.
fail_valid  output  1  a failure has been captured in this sweep.
fail_a  output  WIDTH  operand a of the first failing vector.
fail_b  output  WIDTH  operand b of the first failing vector.

Behaviour:
- Reset (async, any state): state=IDLE; dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_a=0, fail_b=0. Reset mid-sweep aborts the sweep with no partial report.
- Vector index: a 2*WIDTH-bit counter {dut_a, dut_b}. dut_b is the LSB field. Order is (0,0),(0,1)...(0,15),(1,0)...(15,15). All outputs are registered.
- States:
  - IDLE: busy=0. On start, clear err_count, fail_*, done and pass; load index 0; go to WAIT; busy=1.
  - WAIT: hold the vector; a settle counter runs SETTLE cycles, then go to CHECK.
  - CHECK (one cycle): sample dut_greater/equal/less and compare them to the golden values (a>b, a==b, a<b, unsigned).
    - A vector fails on any mismatch, which includes non-one-hot outputs such as all-zero or two-hot.
    - On a fail, err_count increments. If fail_valid=0, capture fail_a/fail_b and set fail_valid=1.
    - If the index is the all-ones value, go to DONE. Otherwise increment the index and go to WAIT.
  - DONE: busy=0, done=1, pass=(final err_count==0). The last vector stays on dut_a/dut_b. A start here behaves exactly as in IDLE.
- err_count holds up to 2^(2*WIDTH) and cannot saturate. Its increment and the done update for the last vector land on the same edge.
- Timing: start sampled at edge k puts vector 0 on dut_* after edge k. Each vector occupies SETTLE+1 cycles. done rises at edge k + 2^(2*WIDTH)*(SETTLE+1), which is 512 cycles for the defaults.
- start while busy is ignored, with no restart and no state change.
- start and rst together: rst wins.
- Comparator inputs are only ever sampled in CHECK; glitches during WAIT have no effect.

Test Plan:
- Correct comparator model, defaults, start pulse at edge k -> busy high for 512 cycles, done=1 at edge k+512, pass=1, err_count=0, fail_valid=0, dut_a=dut_b=15 held.
- Comparator with a_equal stuck at 0 -> err_count=16, pass=0, fail_valid=1, fail_a=0, fail_b=0.
- Comparator with greater/less swapped -> err_count=240, first fail fail_a=0, fail_b=1.
- Comparator asserting a_greater and a_equal together when a==b -> err_count=16 (two-hot counted); with SETTLE=3, done arrives 1024 cycles after start.
- Correct model; extra start pulse at cycle 100 of the sweep -> ignored, done still at k+512. Then a start in DONE -> done drops, err_count cleared, a new sweep completes with pass=1.
- Faulty model; assert rst at cycle 200 mid-sweep -> all outputs zero immediately (async), state IDLE. A later start yields a full clean sweep with the correct count.

Source files
------------

// File: rtl/comparator_bist.sv
// comparator_bist: sweeps every operand pair through an external magnitude comparator,
// checks its result against a golden compare and reports mismatch count and first failure.
module comparator_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   dut_a,
   output logic [WIDTH-1:0]   dut_b,
   input  logic               dut_greater,
   input  logic               dut_equal,
   input  logic               dut_less,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);
   localparam int EW = 2*WIDTH+1;
   typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [WIDTH-1:0] a_n, b_n, fa_n, fb_n;
   logic [EW-1:0] err_n;
   logic busy_n, done_n, pass_n, fv_n, mismatch, last;
   // any deviation from the one-hot golden triple counts, so all-zero and two-hot both fail
   assign mismatch = {dut_greater, dut_equal, dut_less} != {dut_a > dut_b, dut_a == dut_b, dut_a < dut_b};
   assign last = &{dut_a, dut_b};
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      a_n = dut_a;
      b_n = dut_b;
      busy_n = busy;
      done_n = done;
      pass_n = pass;
      err_n = err_count;
      fv_n = fail_valid;
      fa_n = fail_a;
      fb_n = fail_b;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = WAIT;
               cnt_n = '0;
               a_n = '0;
               b_n = '0;
               busy_n = 1'b1;
               done_n = 1'b0;
               pass_n = 1'b0;
               err_n = '0;
               fv_n = 1'b0;
               fa_n = '0;
               fb_n = '0;
            end
         end
         WAIT: begin
            cnt_n = (cnt == 4'(SETTLE - 1)) ? 4'd0 : cnt + 4'd1;
            state_n = (cnt == 4'(SETTLE - 1)) ? CHECK : WAIT;
         end
         CHECK: begin
            if (mismatch) begin
               err_n = err_count + EW'(1);
               if (!fail_valid) begin
                  fv_n = 1'b1;
                  fa_n = dut_a;
                  fb_n = dut_b;
               end
            end
            // pass reflects the last vector's result, which lands on the same edge as done
            if (last) begin
               state_n = DONE;
               busy_n = 1'b0;
               done_n = 1'b1;
               pass_n = (err_n == '0);
            end else begin
               state_n = WAIT;
               {a_n, b_n} = {dut_a, dut_b} + (2*WIDTH)'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         dut_a <= '0;
         dut_b <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         err_count <= '0;
         fail_valid <= 1'b0;
         fail_a <= '0;
         fail_b <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         dut_a <= a_n;
         dut_b <= b_n;
         busy <= busy_n;
         done <= done_n;
         pass <= pass_n;
         err_count <= err_n;
         fail_valid <= fv_n;
         fail_a <= fa_n;
         fail_b <= fb_n;
      end
   end
endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist: drives full sweeps against behavioural comparators with injectable faults.
module tb_comparator_bist;
   localparam int W = 4;
   logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
   int mode0 = 0, mode1 = 0, sel = 0;
   logic [W-1:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
   logic g0, e0, l0, g1, e1, l1, busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
   logic [2*W:0] ec0, ec1;
   logic [2*W-1:0] p0 = '0, p1 = '0;
   int npass = 0, ntot = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      p0 <= {a0, b0};
      p1 <= {a1, b1};
   end
   // mode: 0 good, 1 equal stuck 0, 2 greater/less swapped, 3 two-hot on equal, 4 inverted in first cycle after a vector change
   function automatic logic [2:0] cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int mode, input logic chg);
      logic [2:0] r;
      r = {a > b, a == b, a < b};
      case (mode)
         1: r[1] = 1'b0;
         2: r = {r[0], r[1], r[2]};
         3: if (a == b) r = 3'b110;
         4: if (chg) r = ~r;
         default: ;
      endcase
      return r;
   endfunction
   assign {g0, e0, l0} = cmp(a0, b0, mode0, {a0, b0} != p0);
   assign {g1, e1, l1} = cmp(a1, b1, mode1, {a1, b1} != p1);
   comparator_bist #(.WIDTH(W), .SETTLE(1)) u0 (
      .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0),
      .dut_greater(g0), .dut_equal(e0), .dut_less(l0), .busy(busy0), .done(done0),
      .pass(pass0), .err_count(ec0), .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0));
   comparator_bist #(.WIDTH(W), .SETTLE(3)) u1 (
      .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1),
      .dut_greater(g1), .dut_equal(e1), .dut_less(l1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(ec1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1));
   logic busy_v, done_v, pass_v, fv_v;
   logic [W-1:0] a_v, b_v, fa_v, fb_v;
   logic [2*W:0] ec_v;
   assign busy_v = sel ? busy1 : busy0;
   assign done_v = sel ? done1 : done0;
   assign pass_v = sel ? pass1 : pass0;
   assign fv_v = sel ? fv1 : fv0;
   assign a_v = sel ? a1 : a0;
   assign b_v = sel ? b1 : b0;
   assign fa_v = sel ? fa1 : fa0;
   assign fb_v = sel ? fb1 : fb0;
   assign ec_v = sel ? ec1 : ec0;
   typedef struct {
      int sel;
      int mode;
      int err;
      logic fv;
      logic [W-1:0] fa;
      logic [W-1:0] fb;
      int cyc;
   } vec_t;
   vec_t tbl[6];
   vec_t sb[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   task automatic set_start(input logic v);
      if (sel != 0) start1 = v;
      else start0 = v;
   endtask
   task automatic wait_done(input int extra, output int cyc);
      cyc = 0;
      while (!done_v && cyc < 3000) begin
         @(negedge clk);
         set_start(extra > 0 && cyc == extra);
         cyc++;
      end
      set_start(1'b0);
   endtask
   task automatic run_sweep(input vec_t v, input int extra);
      vec_t r;
      int cyc;
      sel = v.sel;
      if (v.sel != 0) mode1 = v.mode;
      else mode0 = v.mode;
      sb.push_back(v);
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      chk("accept_state", {busy_v, done_v, pass_v, fv_v}, 32'b1000);
      chk("accept_clear", {ec_v, fa_v, fb_v, a_v, b_v}, 0);
      wait_done(extra, cyc);
      r = sb.pop_front();
      chk("done_cycle", cyc, r.cyc);
      chk("err_count", ec_v, r.err);
      chk("pass", pass_v, r.err == 0);
      chk("fail_valid", fv_v, r.fv);
      chk("fail_ab", {fa_v, fb_v}, {r.fa, r.fb});
      chk("last_vec", {a_v, b_v}, 8'hFF);
      chk("done_busy", {done_v, busy_v}, 2'b10);
   endtask
   initial begin
      int cyc;
      tbl[0] = '{0, 0, 0, 1'b0, 4'd0, 4'd0, 512};
      tbl[1] = '{0, 1, 16, 1'b1, 4'd0, 4'd0, 512};
      tbl[2] = '{0, 2, 240, 1'b1, 4'd0, 4'd1, 512};
      tbl[3] = '{1, 3, 16, 1'b1, 4'd0, 4'd0, 1024};
      tbl[4] = '{1, 4, 0, 1'b0, 4'd0, 4'd0, 1024};
      tbl[5] = '{0, 4, 0, 1'b0, 4'd0, 4'd0, 512};
      #1;
      chk("reset0", {busy0, done0, pass0, ec0, fv0, fa0, fb0, a0, b0}, 0);
      chk("reset1", {busy1, done1, pass1, ec1, fv1, fa1, fb1, a1, b1}, 0);
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      chk("rst_wins", {busy0, a0, b0}, 0);
      rst = 1'b0;
      start0 = 1'b0;
      run_sweep(tbl[0], 0);
      run_sweep(tbl[0], 100);
      run_sweep(tbl[0], 0);
      for (int i = 1; i < 6; i++) run_sweep(tbl[i], 0);
      // abort a faulty sweep mid-way with reset
      sel = 0;
      mode0 = 2;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (200) @(negedge clk);
      chk("mid_busy", busy0, 1'b1);
      #2 rst = 1'b1;
      #1 chk("async_rst", {busy0, done0, pass0, ec0, fv0, fa0, fb0, a0, b0}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", {busy0, done0, ec0}, 0);
      run_sweep(tbl[2], 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
